// File: rtl/if_stage_if.sv
`default_nettype none
//============================================================================
// Module   : if_stage_if
// Purpose  : Bundles the instruction-fetch stage control, redirect, loader
//            and result signals. The slave side is the fetch stage; the
//            master side is whatever drives it (hazard unit, branch logic,
//            loader).
// Revision : 1.0 - initial release
//============================================================================
interface if_stage_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 19
);
    // Control from the hazard unit and the branch/jump resolution logic
    logic                   PCwrite;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   jump;
    logic [PC_WIDTH-1:0]    jump_target;

    // Instruction memory loader port
    logic                   imem_we;
    logic [PC_WIDTH-1:0]    imem_waddr;
    logic [INSTR_WIDTH-1:0] imem_wdata;

    // Fetch results
    logic [PC_WIDTH-1:0]    IF_pc;
    logic [PC_WIDTH-1:0]    IF_pc_plus_one;
    logic [INSTR_WIDTH-1:0] IF_instruction;
    logic                   IF_IDflush;
    logic                   halted;
    logic [15:0]            fetch_count;

    modport master (
        output PCwrite, branch_taken, branch_target, jump, jump_target,
        output imem_we, imem_waddr, imem_wdata,
        input  IF_pc, IF_pc_plus_one, IF_instruction, IF_IDflush,
        input  halted, fetch_count
    );

    modport slave (
        input  PCwrite, branch_taken, branch_target, jump, jump_target,
        input  imem_we, imem_waddr, imem_wdata,
        output IF_pc, IF_pc_plus_one, IF_instruction, IF_IDflush,
        output halted, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
//============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage. Holds the PC and the on-chip
//            instruction memory, applies stall and branch/jump redirects,
//            raises the IF/ID flush, and freezes fetch on a HALT opcode.
// Revision : 1.0 - initial release
//============================================================================
module if_stage #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 19,
    parameter int                  IMEM_DEPTH  = 256,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [4:0]          HALT_OPCODE = 5'b11111
) (
    input  wire logic clk,
    input  wire logic rst_n,
    if_stage_if.slave bus
);

    localparam int          c_OPCODE_W  = 5;
    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [PC_WIDTH-1:0]     r_pc;
    logic [PC_WIDTH-1:0]     w_next_pc;
    logic [15:0]             r_fetch_count;
    logic                    w_count_en;
    logic                    w_redirect;
    logic                    w_is_halt;
    logic [INSTR_WIDTH-1:0]  w_instr;

    // Instruction memory has no reset; only the loader port changes it.
    logic [INSTR_WIDTH-1:0]  r_imem [IMEM_DEPTH];

    // Combinational read of the word addressed by the current PC
    assign w_instr    = r_imem[r_pc];
    assign w_is_halt  = (w_instr[INSTR_WIDTH-1 -: c_OPCODE_W] == HALT_OPCODE);
    assign w_redirect = bus.branch_taken | bus.jump;

    // Loader write; writes are dropped while the stage is held in reset
    always_ff @(posedge clk) begin
        if (rst_n && bus.imem_we) begin
            r_imem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // Next-PC / next-state selection; redirect outranks halt and stall
    // because the stalled or halting instruction is on a wrong path.
    always_comb begin
        w_next_pc    = r_pc;
        w_next_state = r_state;
        w_count_en   = 1'b0;
        if (bus.branch_taken) begin
            w_next_pc    = bus.branch_target;
            w_next_state = ST_RUN;
        end else if (bus.jump) begin
            w_next_pc    = bus.jump_target;
            w_next_state = ST_RUN;
        end else if (r_state == ST_HALTED) begin
            w_next_pc    = r_pc;
        end else if (!bus.PCwrite) begin
            w_next_pc    = r_pc;
        end else if (w_is_halt) begin
            w_next_pc    = r_pc;
            w_next_state = ST_HALTED;
        end else begin
            w_next_pc    = r_pc + 1'b1;
            w_count_en   = 1'b1;
        end
    end

    // PC and fetch-state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
        end else begin
            r_pc    <= w_next_pc;
            r_state <= w_next_state;
        end
    end

    // Saturating count of instructions that advanced the PC sequentially
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 16'd0;
        end else if (w_count_en && (r_fetch_count != c_COUNT_MAX)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign bus.IF_pc          = r_pc;
    assign bus.IF_pc_plus_one = r_pc + 1'b1;
    assign bus.IF_instruction = w_instr;
    assign bus.IF_IDflush     = w_redirect;
    assign bus.halted         = (r_state == ST_HALTED);
    assign bus.fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
//============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage: a vector table of inputs and
//            expected pre-edge outputs, with post-edge PC/count expectations
//            queued as a scoreboard, plus hand-written reset/memory cases.
// Revision : 1.0 - initial release
//============================================================================
module tb_if_stage;

    logic clk;
    logic rst_n;

    if_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(19)) bus ();

    if_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pcw;
        logic        br;
        logic [7:0]  bt;
        logic        jp;
        logic [7:0]  jt;
        logic [7:0]  pc;
        logic        flush;
        logic        hlt;
        logic [15:0] cnt;
        logic [7:0]  npc;
        logic [15:0] ncnt;
    } vec_t;

    typedef struct {
        logic [7:0]  npc;
        logic [15:0] ncnt;
    } sb_t;

    vec_t        vq[$];
    sb_t         sbq[$];
    logic [18:0] shadow [256];
    int          n_vec;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic pcw, input logic br, input logic [7:0] bt,
                        input logic jp, input logic [7:0] jt, input logic [7:0] pc,
                        input logic flush, input logic hlt, input logic [15:0] cnt,
                        input logic [7:0] npc, input logic [15:0] ncnt);
        vec_t v;
        v.pcw = pcw; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
        v.pc = pc; v.flush = flush; v.hlt = hlt; v.cnt = cnt;
        v.npc = npc; v.ncnt = ncnt;
        vq.push_back(v);
    endtask

    initial begin
        sb_t        s;
        logic [7:0] eppo;

        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.PCwrite = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 8'h00;
        bus.jump = 1'b0; bus.jump_target = 8'h00;
        bus.imem_we = 1'b0; bus.imem_waddr = 8'h00; bus.imem_wdata = 19'h0;

        // Stream / stall / redirect / wrap / halt table
        //    pcw br bt     jp jt     pc    fl hl cnt  npc   ncnt
        addv(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0,  8'h01, 1);
        addv(1, 0, 8'h00, 0, 8'h00, 8'h01, 0, 0, 1,  8'h02, 2);
        addv(1, 0, 8'h00, 0, 8'h00, 8'h02, 0, 0, 2,  8'h03, 3);
        addv(0, 0, 8'h00, 0, 8'h00, 8'h03, 0, 0, 3,  8'h03, 3);
        addv(0, 0, 8'h00, 0, 8'h00, 8'h03, 0, 0, 3,  8'h03, 3);
        addv(1, 0, 8'h00, 0, 8'h00, 8'h03, 0, 0, 3,  8'h04, 4);
        addv(0, 1, 8'h40, 0, 8'h00, 8'h04, 1, 0, 4,  8'h40, 4);
        addv(1, 1, 8'h20, 1, 8'h30, 8'h40, 1, 0, 4,  8'h20, 4);
        addv(1, 0, 8'h00, 1, 8'hFF, 8'h20, 1, 0, 4,  8'hFF, 4);
        addv(1, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 4,  8'h00, 5);
        for (int i = 0; i < 7; i++)
            addv(1, 0, 8'h00, 0, 8'h00, 8'(i), 0, 0, 16'(5 + i), 8'(i + 1), 16'(6 + i));
        // HALT word fetched during a stall: no transition yet
        addv(0, 0, 8'h00, 0, 8'h00, 8'h07, 0, 0, 12, 8'h07, 12);
        addv(1, 0, 8'h00, 0, 8'h00, 8'h07, 0, 0, 12, 8'h07, 12);
        for (int i = 0; i < 5; i++)
            addv(1, 0, 8'h00, 0, 8'h00, 8'h07, 0, 1, 12, 8'h07, 12);
        addv(1, 0, 8'h00, 1, 8'h10, 8'h07, 1, 1, 12, 8'h10, 12);
        addv(1, 0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 12, 8'h11, 13);
        addv(1, 0, 8'h00, 0, 8'h00, 8'h11, 0, 0, 13, 8'h12, 14);

        // Bring the stage out of reset with fetch stalled, then load memory
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 256; a++) begin
            shadow[a] = (a == 7) ? 19'h7C000 : 19'(a);
            bus.imem_we    = 1'b1;
            bus.imem_waddr = 8'(a);
            bus.imem_wdata = shadow[a];
            @(posedge clk);
            #1;
        end
        bus.imem_we = 1'b0;

        // Reset values
        rst_n = 1'b0;
        #1;
        chk("reset_pc",     32'(bus.IF_pc), 32'h00);
        chk("reset_ppo",    32'(bus.IF_pc_plus_one), 32'h01);
        chk("reset_halted", 32'(bus.halted), 32'h0);
        chk("reset_count",  32'(bus.fetch_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven run with post-edge scoreboard
        foreach (vq[i]) begin
            bus.PCwrite       = vq[i].pcw;
            bus.branch_taken  = vq[i].br;
            bus.branch_target = vq[i].bt;
            bus.jump          = vq[i].jp;
            bus.jump_target   = vq[i].jt;
            #3;
            eppo = vq[i].pc + 8'd1;
            chk($sformatf("v%0d_pc", i),     32'(bus.IF_pc), 32'(vq[i].pc));
            chk($sformatf("v%0d_ppo", i),    32'(bus.IF_pc_plus_one), 32'(eppo));
            chk($sformatf("v%0d_instr", i),  32'(bus.IF_instruction), 32'(shadow[vq[i].pc]));
            chk($sformatf("v%0d_flush", i),  32'(bus.IF_IDflush), 32'(vq[i].flush));
            chk($sformatf("v%0d_halted", i), 32'(bus.halted), 32'(vq[i].hlt));
            chk($sformatf("v%0d_count", i),  32'(bus.fetch_count), 32'(vq[i].cnt));
            s.npc  = vq[i].npc;
            s.ncnt = vq[i].ncnt;
            sbq.push_back(s);
            @(posedge clk);
            #1;
            s = sbq.pop_front();
            chk($sformatf("v%0d_next_pc", i),    32'(bus.IF_pc), 32'(s.npc));
            chk($sformatf("v%0d_next_count", i), 32'(bus.fetch_count), 32'(s.ncnt));
        end

        // Asynchronous reset between edges, mid-run at PC 0x12
        bus.PCwrite = 1'b1;
        bus.branch_taken = 1'b0;
        bus.jump = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc",     32'(bus.IF_pc), 32'h00);
        chk("async_ppo",    32'(bus.IF_pc_plus_one), 32'h01);
        chk("async_halted", 32'(bus.halted), 32'h0);
        chk("async_count",  32'(bus.fetch_count), 32'h0);

        // Loader write while in reset must be dropped
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 8'h05;
        bus.imem_wdata = 19'h5AAAA;
        @(posedge clk);
        #1;
        bus.imem_we = 1'b0;
        bus.PCwrite = 1'b0;
        rst_n = 1'b1;
        bus.jump = 1'b1;
        bus.jump_target = 8'h05;
        #3;
        chk("rst_jump_flush", 32'(bus.IF_IDflush), 32'h1);
        @(posedge clk);
        #1;
        bus.jump = 1'b0;
        chk("rst_jump_pc",      32'(bus.IF_pc), 32'h05);
        chk("rst_write_ignored", 32'(bus.IF_instruction), 32'(shadow[5]));

        // Write to the word being read: old data until the write edge
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 8'h05;
        bus.imem_wdata = 19'h01234;
        #2;
        chk("wr_old_data", 32'(bus.IF_instruction), 32'(shadow[5]));
        @(posedge clk);
        #1;
        bus.imem_we = 1'b0;
        shadow[5] = 19'h01234;
        chk("wr_new_data",   32'(bus.IF_instruction), 32'(shadow[5]));
        chk("stall_count_0", 32'(bus.fetch_count), 32'h0);
        chk("stall_pc",      32'(bus.IF_pc), 32'h05);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
